// File: rtl/spi_btn_slave.sv
// SPI mode-0 slave that lets the ESP32 read debounced buttons, sticky press flags and an ID byte.
// MOSI byte 0 of every frame is latched onto the LEDs.
module spi_btn_slave #(
    parameter int               C_width = 8,
    parameter logic [7:0]       C_id    = 8'hB5,
    parameter int               C_sync  = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [C_width-1:0] i_btn,
    input  logic               i_sclk,
    input  logic               i_csn,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    output logic [C_width-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic [C_width-1:0] o_led,
    output logic               o_busy
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    logic [C_sync-1:0]  sclkSync_q, csnSync_q, mosiSync_q;
    logic               sclkPrev_q, csnPrev_q;
    logic [C_width-1:0] btn_q;

    state_t             state_q, state_d;
    logic [C_width-1:0] tx_q, tx_d;
    logic [C_width-1:0] rx_q, rx_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [C_width-1:0] snap_q, snap_d;
    logic [C_width-1:0] flags_q, flags_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic [C_width-1:0] rxData_q, rxData_d;
    logic               rxValid_q, rxValid_d;
    logic [C_width-1:0] led_q, led_d;
    logic               lastBit_q, lastBit_d;

    logic               sclkS, csnS, mosiS;
    logic               sclkRise, sclkFall, csnRise, csnFall;
    logic [C_width-1:0] newEdges;
    logic [C_width-1:0] rxShift;
    logic [C_width-1:0] nextByte;

    assign sclkS    = sclkSync_q[C_sync-1];
    assign csnS     = csnSync_q[C_sync-1];
    assign mosiS    = mosiSync_q[C_sync-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign sclkFall = ~sclkS & sclkPrev_q;
    assign csnRise  = csnS & ~csnPrev_q;
    assign csnFall  = ~csnS & csnPrev_q;
    assign newEdges = i_btn & ~btn_q;
    assign rxShift  = {rx_q[C_width-2:0], mosiS};

    // Idle levels of the synchronizers match an undriven bus: SCLK low, CSn high.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sclkSync_q <= '0;
            csnSync_q  <= '1;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csnPrev_q  <= 1'b1;
            btn_q      <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[C_sync-2:0], i_sclk};
            csnSync_q  <= {csnSync_q[C_sync-2:0], i_csn};
            mosiSync_q <= {mosiSync_q[C_sync-2:0], i_mosi};
            sclkPrev_q <= sclkS;
            csnPrev_q  <= csnS;
            btn_q      <= i_btn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            snap_q    <= '0;
            flags_q   <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            led_q     <= '0;
            lastBit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            snap_q    <= snap_d;
            flags_q   <= flags_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            led_q     <= led_d;
            lastBit_q <= lastBit_d;
        end
    end

    // Byte presented after the 8th bit; byte_q has already advanced by then.
    always_comb begin
        case (byte_q)
            2'd1:    nextByte = snap_q;
            2'd2:    nextByte = C_id;
            default: nextByte = '0;
        endcase
    end

    // CSn release outranks everything so a partial byte never commits.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        snap_d    = snap_q;
        flags_d   = flags_q | newEdges;
        miso_d    = miso_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rxData_d  = rxData_q;
        rxValid_d = 1'b0;
        led_d     = led_q;
        lastBit_d = lastBit_q;

        if (csnRise) begin
            state_d   = S_IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_d     = '0;
            byte_d    = '0;
            lastBit_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    oe_d = 1'b0;
                    if (csnFall) begin
                        tx_d      = i_btn;
                        snap_d    = flags_q;
                        bit_d     = '0;
                        byte_d    = '0;
                        lastBit_d = 1'b0;
                        miso_d    = i_btn[C_width-1];
                        oe_d      = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sclkRise) begin
                        rx_d      = rxShift;
                        bit_d     = bit_q + 3'd1;
                        lastBit_d = (bit_q == 3'd7);
                        if (bit_q == 3'd7) begin
                            rxData_d  = rxShift;
                            rxValid_d = 1'b1;
                            if (byte_q == 2'd0) begin
                                led_d = rxShift;
                            end
                            if (byte_q == 2'd1) begin
                                flags_d = (flags_q & ~snap_q) | newEdges;
                            end
                            if (byte_q != 2'd3) begin
                                byte_d = byte_q + 2'd1;
                            end
                        end
                    end else if (sclkFall) begin
                        if (lastBit_q) begin
                            tx_d   = nextByte;
                            miso_d = nextByte[C_width-1];
                        end else begin
                            tx_d   = tx_q << 1;
                            miso_d = tx_q[C_width-2];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_miso     = miso_q;
    assign o_miso_oe  = oe_q;
    assign o_rx_data  = rxData_q;
    assign o_rx_valid = rxValid_q;
    assign o_led      = led_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_btn_slave.sv
// Directed bench for spi_btn_slave: acts as the SPI master and checks every frame byte,
// LED/rx outputs and o_rx_valid pulse counts against hand-computed values.
module tb_spi_btn_slave;

    logic       clk;
    logic       rstn;
    logic [7:0] btn;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic       misoOe;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] led;
    logic       busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int validCount  = 0;

    typedef struct {
        logic [7:0]  btnLevel;
        logic [7:0]  pressMask;
        int          nBytes;
        logic [39:0] mosiBytes;
        logic [39:0] expMiso;
        logic [7:0]  expLed;
    } vec_t;

    vec_t vecs[6];

    spi_btn_slave dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_btn      (btn),
        .i_sclk     (sclk),
        .i_csn      (csn),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (misoOe),
        .o_rx_data  (rxData),
        .o_rx_valid (rxValid),
        .o_led      (led),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (rxValid) validCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset(input logic [7:0] btnVal);
        rstn = 1'b0;
        btn  = btnVal;
        csn  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        waitCycles(3);
        rstn = 1'b1;
        waitCycles(3);
    endtask

    // Shifts nBits of one byte MSB first; MISO is sampled just before each rising SCLK.
    task automatic spiByte(input logic [7:0] txByte, input int nBits, input bit injectBtn6,
                           output logic [7:0] rxByte);
        rxByte = '0;
        for (int b = 7; b > 7 - nBits; b--) begin
            mosi = txByte[b];
            waitCycles(5);
            rxByte[b] = miso;
            sclk = 1'b1;
            if (injectBtn6 && b == 0) begin
                waitCycles(2);
                btn[6] = 1'b1;
                waitCycles(3);
            end else begin
                waitCycles(5);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic runFrame(input int nBytes, input logic [39:0] txBytes, input int injectByte,
                            output logic [39:0] rxBytes);
        logic [7:0] b;
        rxBytes = '0;
        csn = 1'b0;
        waitCycles(5);
        for (int k = 0; k < nBytes; k++) begin
            spiByte(txBytes[39-8*k -: 8], 8, (k == injectByte), b);
            rxBytes[39-8*k -: 8] = b;
        end
        waitCycles(5);
        csn = 1'b1;
        waitCycles(6);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [39:0] rxBytes);
        btn = v.btnLevel | v.pressMask;
        waitCycles(2);
        btn = v.btnLevel;
        waitCycles(2);
        runFrame(v.nBytes, v.mosiBytes, -1, rxBytes);
    endtask

    initial begin
        logic [39:0] got;
        logic [7:0]  b;
        int          startValid;
        logic [7:0]  ledBefore;

        vecs[0] = '{8'h00, 8'h04, 3, {8'hA1, 8'h00, 8'h00, 16'h0}, {8'h00, 8'h04, 8'hB5, 16'h0}, 8'hA1};
        vecs[1] = '{8'h00, 8'h00, 3, {8'h5A, 8'h01, 8'h02, 16'h0}, {8'h00, 8'h00, 8'hB5, 16'h0}, 8'h5A};
        vecs[2] = '{8'h30, 8'h00, 5, {8'hC3, 8'h11, 8'h22, 8'h33, 8'h44}, {8'h30, 8'h30, 8'hB5, 8'h00, 8'h00}, 8'hC3};
        vecs[3] = '{8'h30, 8'h00, 2, {8'h0F, 8'hFF, 24'h0}, {8'h30, 8'h00, 24'h0}, 8'h0F};
        vecs[4] = '{8'h00, 8'h81, 2, {8'hE7, 8'h00, 24'h0}, {8'h00, 8'h81, 24'h0}, 8'hE7};
        vecs[5] = '{8'h00, 8'h00, 1, {8'h99, 32'h0}, {8'h00, 32'h0}, 8'h99};

        rstn = 1'b0;
        btn  = 8'h05;
        csn  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        waitCycles(3);
        checkOutput("reset_miso", {31'b0, miso}, 32'h0);
        checkOutput("reset_oe", {31'b0, misoOe}, 32'h0);
        checkOutput("reset_rxdata", {24'b0, rxData}, 32'h0);
        checkOutput("reset_rxvalid", {31'b0, rxValid}, 32'h0);
        checkOutput("reset_led", {24'b0, led}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        rstn = 1'b1;
        waitCycles(3);

        // Single byte frame straight out of reset.
        startValid = validCount;
        csn = 1'b0;
        waitCycles(3);
        checkOutput("t1_oe_latency", {31'b0, misoOe}, 32'h1);
        checkOutput("t1_busy", {31'b0, busy}, 32'h1);
        waitCycles(2);
        spiByte(8'h3C, 8, 1'b0, b);
        waitCycles(5);
        csn = 1'b1;
        waitCycles(6);
        checkOutput("t1_miso", {24'b0, b}, 32'h05);
        checkOutput("t1_rxdata", {24'b0, rxData}, 32'h3C);
        checkOutput("t1_valid_count", validCount - startValid, 1);
        checkOutput("t1_led", {24'b0, led}, 32'h3C);
        checkOutput("t1_oe_after", {31'b0, misoOe}, 32'h0);

        // Partial byte aborted by CSn after 5 SCLK pulses.
        startValid = validCount;
        ledBefore  = led;
        csn = 1'b0;
        waitCycles(5);
        spiByte(8'hFF, 5, 1'b0, b);
        waitCycles(5);
        csn = 1'b1;
        waitCycles(3);
        checkOutput("abort_oe", {31'b0, misoOe}, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        waitCycles(3);
        checkOutput("abort_valid_count", validCount - startValid, 0);
        checkOutput("abort_led", {24'b0, led}, {24'b0, ledBefore});
        startValid = validCount;
        runFrame(1, {8'h66, 32'h0}, -1, got);
        checkOutput("abort_next_miso", {24'b0, got[39:32]}, 32'h05);
        checkOutput("abort_next_led", {24'b0, led}, 32'h66);
        checkOutput("abort_next_valid", validCount - startValid, 1);

        // Table-driven frames, sticky flags carried from entry to entry.
        doReset(8'h00);
        for (int i = 0; i < 6; i++) begin
            startValid = validCount;
            applyStimulus(vecs[i], got);
            for (int k = 0; k < vecs[i].nBytes; k++) begin
                checkOutput($sformatf("vec%0d_byte%0d", i, k), {24'b0, got[39-8*k -: 8]},
                            {24'b0, vecs[i].expMiso[39-8*k -: 8]});
            end
            checkOutput($sformatf("vec%0d_led", i), {24'b0, led}, {24'b0, vecs[i].expLed});
            checkOutput($sformatf("vec%0d_rxdata", i), {24'b0, rxData},
                        {24'b0, vecs[i].mosiBytes[39-8*(vecs[i].nBytes-1) -: 8]});
            checkOutput($sformatf("vec%0d_valid_count", i), validCount - startValid, vecs[i].nBytes);
        end

        // Press on btn[6] lands in the same cycle as the byte-1 clear.
        doReset(8'h00);
        btn = 8'h04;
        waitCycles(2);
        btn = 8'h00;
        waitCycles(2);
        runFrame(2, {8'h12, 8'h34, 24'h0}, 1, got);
        checkOutput("clr_race_byte1", {24'b0, got[31:24]}, 32'h04);
        btn = 8'h00;
        waitCycles(2);
        runFrame(2, {8'h12, 8'h34, 24'h0}, -1, got);
        checkOutput("clr_race_next_byte1", {24'b0, got[31:24]}, 32'h40);
        runFrame(2, {8'h12, 8'h34, 24'h0}, -1, got);
        checkOutput("clr_race_cleared", {24'b0, got[31:24]}, 32'h00);

        // Asynchronous reset in the middle of byte 1 with flags = 8'h81.
        doReset(8'h00);
        btn = 8'h81;
        waitCycles(2);
        btn = 8'h00;
        waitCycles(2);
        csn = 1'b0;
        waitCycles(5);
        spiByte(8'hA5, 8, 1'b0, b);
        spiByte(8'hFF, 3, 1'b0, b);
        waitCycles(2);
        checkOutput("mid_busy_before", {31'b0, busy}, 32'h1);
        rstn = 1'b0;
        #5;
        checkOutput("mid_rst_miso", {31'b0, miso}, 32'h0);
        checkOutput("mid_rst_oe", {31'b0, misoOe}, 32'h0);
        checkOutput("mid_rst_rxdata", {24'b0, rxData}, 32'h0);
        checkOutput("mid_rst_rxvalid", {31'b0, rxValid}, 32'h0);
        checkOutput("mid_rst_led", {24'b0, led}, 32'h0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
        csn  = 1'b1;
        sclk = 1'b0;
        waitCycles(3);
        rstn = 1'b1;
        waitCycles(3);
        runFrame(2, {8'h00, 8'h00, 24'h0}, -1, got);
        checkOutput("mid_rst_next_byte1", {24'b0, got[31:24]}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
